// File: rtl/char_pkg.sv
// Shared types, widths and helpers for the character jump sequencer.
package char_pkg;

  localparam int unsigned POS_W = 11;
  localparam int unsigned VEL_W = 6;
  localparam int unsigned SPD_W = 4;

  // Encoding is visible on char_state and drives sprite selection.
  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StCharge  = 3'd1,
    StAscend  = 3'd2,
    StDescend = 3'd3,
    StDead    = 3'd4
  } char_state_e;

  // Saturating increment for 6-bit charge / velocity values.
  function automatic logic [VEL_W-1:0] sat_inc(input logic [VEL_W-1:0] v,
                                               input logic [VEL_W-1:0] lim);
    if (v >= lim) return lim;
    return v + VEL_W'(1);
  endfunction

  // One horizontal move of `speed` pixels, clamped to [lo, hi].
  // Compares are done one bit wider so nothing wraps near the edges.
  function automatic logic [POS_W-1:0] x_step(input logic [POS_W-1:0] x,
                                              input logic             right,
                                              input logic [SPD_W-1:0] speed,
                                              input logic [POS_W-1:0] lo,
                                              input logic [POS_W-1:0] hi);
    logic [POS_W:0] wide_spd;
    logic [POS_W:0] wide;
    wide_spd = {{(POS_W + 1 - SPD_W){1'b0}}, speed};
    if (right) begin
      wide = {1'b0, x} + wide_spd;
      if (wide > {1'b0, hi}) return hi;
      return wide[POS_W-1:0];
    end else begin
      if ({1'b0, x} < ({1'b0, lo} + wide_spd)) return lo;
      wide = {1'b0, x} - wide_spd;
      return wide[POS_W-1:0];
    end
  endfunction

endpackage

// File: rtl/char_step_div.sv
// Divides the movement-timer strobe into physics steps.
module char_step_div #(
  parameter int unsigned STEP_TICKS = 8
) (
  input  logic clk_40MHz,
  input  logic rst_n,
  input  logic movement_tick,
  output logic phys_step
);

  localparam int unsigned CntW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(STEP_TICKS - 1);

  logic [CntW-1:0] step_cnt_q;

  assign phys_step = movement_tick && (step_cnt_q == CntLast);

  // Free-running tick counter, wraps at STEP_TICKS-1 in every FSM state.
  always_ff @(posedge clk_40MHz or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt_q <= '0;
    end else if (movement_tick) begin
      if (step_cnt_q == CntLast) step_cnt_q <= '0;
      else                       step_cnt_q <= step_cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/char_jump_ctrl.sv
// Jump/physics sequencer: charge, ascend, descend and death of the player character.
module char_jump_ctrl
  import char_pkg::*;
#(
  parameter int unsigned      STEP_TICKS = 8,
  parameter logic [POS_W-1:0] X_START    = 11'd400,
  parameter logic [POS_W-1:0] Y_START    = 11'd500,
  parameter logic [POS_W-1:0] X_MIN      = 11'd0,
  parameter logic [POS_W-1:0] X_MAX      = 11'd760,
  parameter logic [POS_W-1:0] Y_MIN      = 11'd0,
  parameter logic [POS_W-1:0] Y_MAX      = 11'd599,
  parameter logic [VEL_W-1:0] CHARGE_MAX = 6'd40,
  parameter logic [VEL_W-1:0] VY_MAX     = 6'd12,
  parameter logic [SPD_W-1:0] H_SPEED    = 4'd3
) (
  input  logic             clk_40MHz,
  input  logic             rst_n,
  input  logic             movement_tick,
  input  logic             jump_btn,
  input  logic             dir,
  input  logic             on_platform,
  output logic [POS_W-1:0] xpos,
  output logic [POS_W-1:0] ypos,
  output logic [2:0]       char_state,
  output logic             fell
);

  logic phys_step;

  char_step_div #(
    .STEP_TICKS(STEP_TICKS)
  ) u_step_div (
    .clk_40MHz    (clk_40MHz),
    .rst_n        (rst_n),
    .movement_tick(movement_tick),
    .phys_step    (phys_step)
  );

  char_state_e      state_q;
  logic [POS_W-1:0] xpos_q;
  logic [POS_W-1:0] ypos_q;
  logic [VEL_W-1:0] vy_q;
  logic [VEL_W-1:0] charge_q;
  logic             dir_q;
  logic             horiz_en_q;
  logic             fell_q;

  // 12-bit views of the vertical quantities for wrap-free compares.
  logic [POS_W:0]   ypos_w;
  logic [POS_W:0]   vy_w;
  logic [POS_W:0]   ceil_hit_w;
  logic [POS_W:0]   floor_hit_w;
  logic [POS_W-1:0] x_next;

  // Combinational helpers shared by the ASCEND and DESCEND updates.
  always_comb begin
    ypos_w      = {1'b0, ypos_q};
    vy_w        = {{(POS_W + 1 - VEL_W){1'b0}}, vy_q};
    ceil_hit_w  = {1'b0, Y_MIN} + vy_w;
    floor_hit_w = ypos_w + vy_w;
    x_next      = x_step(xpos_q, dir_q, H_SPEED, X_MIN, X_MAX);
  end

  // FSM and position datapath; everything advances only on a physics step.
  always_ff @(posedge clk_40MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      xpos_q     <= X_START;
      ypos_q     <= Y_START;
      vy_q       <= '0;
      charge_q   <= '0;
      dir_q      <= 1'b1;
      horiz_en_q <= 1'b0;
      fell_q     <= 1'b0;
    end else begin
      // fell is a pulse: it only survives the cycle of entry into StDead.
      fell_q <= 1'b0;
      if (phys_step) begin
        unique case (state_q)
          StIdle: begin
            // Walking off a ledge beats a jump request.
            if (!on_platform) begin
              state_q <= StDescend;
              vy_q    <= '0;
            end else if (jump_btn) begin
              state_q  <= StCharge;
              charge_q <= '0;
            end
          end
          StCharge: begin
            if (jump_btn) begin
              charge_q <= sat_inc(charge_q, CHARGE_MAX);
            end else if (charge_q == '0) begin
              state_q <= StIdle;
            end else begin
              state_q    <= StAscend;
              vy_q       <= charge_q;
              dir_q      <= dir;
              horiz_en_q <= 1'b1;
              charge_q   <= '0;
            end
          end
          StAscend: begin
            // Platforms are ignored on the way up so the character passes through.
            if (ypos_w < ceil_hit_w) begin
              ypos_q  <= Y_MIN;
              vy_q    <= '0;
              state_q <= StDescend;
            end else begin
              ypos_q <= ypos_q - POS_W'(vy_q);
              vy_q   <= (vy_q == '0) ? '0 : vy_q - VEL_W'(1);
              if (vy_q <= VEL_W'(1)) state_q <= StDescend;
            end
            if (horiz_en_q) xpos_q <= x_next;
          end
          StDescend: begin
            if (on_platform) begin
              state_q    <= StIdle;
              vy_q       <= '0;
              horiz_en_q <= 1'b0;
            end else if (floor_hit_w >= {1'b0, Y_MAX}) begin
              ypos_q  <= Y_MAX;
              fell_q  <= 1'b1;
              state_q <= StDead;
            end else begin
              ypos_q <= ypos_q + POS_W'(vy_q);
              vy_q   <= sat_inc(vy_q, VY_MAX);
              if (horiz_en_q) xpos_q <= x_next;
            end
          end
          StDead: begin
            // Terminal until reset.
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign xpos       = xpos_q;
  assign ypos       = ypos_q;
  assign char_state = state_q;
  assign fell       = fell_q;

endmodule

// File: tb/tb_char_jump_ctrl.sv
// Directed bench for char_jump_ctrl with STEP_TICKS=2 and a tick every 4 cycles.
module tb_char_jump_ctrl;

  logic        clk_40MHz = 1'b0;
  logic        rst_n = 1'b1;
  logic        movement_tick = 1'b0;
  logic        jump_btn = 1'b0;
  logic        dir = 1'b1;
  logic        on_platform = 1'b1;
  logic [10:0] xpos;
  logic [10:0] ypos;
  logic [2:0]  char_state;
  logic        fell;

  int total = 0;
  int bad   = 0;

  always #5 clk_40MHz = ~clk_40MHz;

  char_jump_ctrl #(
    .STEP_TICKS(2)
  ) dut (
    .clk_40MHz    (clk_40MHz),
    .rst_n        (rst_n),
    .movement_tick(movement_tick),
    .jump_btn     (jump_btn),
    .dir          (dir),
    .on_platform  (on_platform),
    .xpos         (xpos),
    .ypos         (ypos),
    .char_state   (char_state),
    .fell         (fell)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int x, input int y, input int s,
                           input int f);
    check({tag, ".x"}, 32'(xpos), 32'(x));
    check({tag, ".y"}, 32'(ypos), 32'(y));
    check({tag, ".st"}, 32'(char_state), 32'(s));
    check({tag, ".fell"}, 32'(fell), 32'(f));
  endtask

  // One movement tick, 4 cycles long.
  task automatic tick();
    @(negedge clk_40MHz) movement_tick = 1'b1;
    @(negedge clk_40MHz) movement_tick = 1'b0;
    @(negedge clk_40MHz);
    @(negedge clk_40MHz);
  endtask

  // One physics step; returns at the negedge just after the stepping posedge.
  task automatic step();
    tick();
    @(negedge clk_40MHz) movement_tick = 1'b1;
    @(negedge clk_40MHz) movement_tick = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_40MHz) rst_n = 1'b0;
    @(negedge clk_40MHz) rst_n = 1'b1;
  endtask

  initial begin
    // Reset state, observed while reset is asserted.
    #1 rst_n = 1'b0;
    #2 check_all("reset", 400, 500, 0, 0);
    @(negedge clk_40MHz) rst_n = 1'b1;

    // Idle on a platform: nothing moves for 100 steps.
    for (int i = 0; i < 100; i++) begin
      step();
      check("idle_hold", 32'({xpos, ypos, char_state, fell}),
            32'({11'd400, 11'd500, 3'd0, 1'b0}));
    end

    // Charge for 5 steps (charge 0..4), release, ascend vy=4 to the right.
    jump_btn = 1'b1;
    dir      = 1'b1;
    step();
    check("charge_enter", 32'(char_state), 32'd1);
    repeat (4) step();
    check_all("charge_held", 400, 500, 1, 0);
    jump_btn = 1'b0;
    step();
    check_all("launch", 400, 500, 2, 0);
    step();
    check_all("asc1", 403, 496, 2, 0);
    step();
    check_all("asc2", 406, 493, 2, 0);
    step();
    check_all("asc3", 409, 491, 2, 0);
    step();
    check_all("apex", 412, 490, 3, 0);
    step();
    check_all("land", 412, 490, 0, 0);

    // One-step press: CHARGE with zero charge, then back to IDLE without launch.
    jump_btn = 1'b1;
    step();
    check("pulse_charge", 32'(char_state), 32'd1);
    jump_btn = 1'b0;
    step();
    check_all("pulse_back", 412, 490, 0, 0);

    // A press between physics steps is never sampled.
    tick();
    jump_btn = 1'b1;
    @(negedge clk_40MHz) jump_btn = 1'b0;
    @(negedge clk_40MHz) movement_tick = 1'b1;
    @(negedge clk_40MHz) movement_tick = 1'b0;
    check("glitch_ignored", 32'(char_state), 32'd0);

    // Short left jump: charge 1, vy=1, one step up and 3 px left.
    jump_btn = 1'b1;
    step();
    step();
    jump_btn = 1'b0;
    dir      = 1'b0;
    step();
    check("left_launch", 32'(char_state), 32'd2);
    step();
    check_all("left_apex", 409, 489, 3, 0);
    step();
    check("left_land", 32'(char_state), 32'd0);
    dir = 1'b1;

    // Charge saturation at 40 and ceiling clamp.
    do_reset();
    jump_btn = 1'b1;
    repeat (60) step();
    check_all("sat_charging", 400, 500, 1, 0);
    jump_btn = 1'b0;
    step();
    check("sat_launch", 32'(char_state), 32'd2);
    step();
    check_all("sat_asc1", 403, 460, 2, 0);
    repeat (13) step();
    check_all("sat_asc14", 442, 31, 2, 0);
    step();
    check_all("sat_asc15", 445, 5, 2, 0);
    step();
    check_all("ceiling", 448, 0, 3, 0);
    step();
    check_all("ceil_land", 448, 0, 0, 0);

    // Walk-off fall from IDLE: no horizontal motion, vy saturates at 12, dies at floor.
    do_reset();
    on_platform = 1'b0;
    step();
    check_all("drop", 400, 500, 3, 0);
    step();
    check("fall_d1", 32'(ypos), 32'd500);
    step();
    check("fall_d2", 32'(ypos), 32'd501);
    step();
    check("fall_d3", 32'(ypos), 32'd503);
    repeat (8) step();
    check("fall_d11", 32'(ypos), 32'd555);
    step();
    check("fall_d12", 32'(ypos), 32'd566);
    step();
    check("fall_d13", 32'(ypos), 32'd578);
    step();
    check_all("fall_d14", 400, 590, 3, 0);
    step();
    check_all("death", 400, 599, 4, 1);
    @(negedge clk_40MHz);
    check_all("death_next", 400, 599, 4, 0);
    on_platform = 1'b1;
    jump_btn    = 1'b1;
    repeat (3) step();
    check_all("dead_hold", 400, 599, 4, 0);
    jump_btn = 1'b0;

    // Asynchronous reset mid-ascend, taking effect before the next clock edge.
    do_reset();
    jump_btn = 1'b1;
    repeat (4) step();
    jump_btn = 1'b0;
    step();
    step();
    check_all("pre_reset_asc", 403, 497, 2, 0);
    tick();
    @(negedge clk_40MHz);
    #1 rst_n = 1'b0;
    #1 check_all("async_reset", 400, 500, 0, 0);
    @(negedge clk_40MHz) rst_n = 1'b1;
    // Divider restarted at zero: a single tick is not a physics step.
    on_platform = 1'b0;
    tick();
    check("div_reset_tick1", 32'(char_state), 32'd0);
    tick();
    check("div_reset_tick2", 32'(char_state), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
